// File: rtl/instr_encoder_loader.sv
// Encodes decoded RV32I fields into 32-bit words, queues them and drains them to instruction memory.
// Latency: an accepted bundle reaches mem_wdata with mem_we=1 on the cycle after the push.
// Backpressure: in_ready drops while the FIFO is full; mem_ready=0 holds the head word and address.

// Generic synchronous FIFO with a synchronous flush; depth must be a power of two.
module fifo_sync #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdat_i,
  input  logic         pop_i,
  output logic [W-1:0] rdat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdat_o  = mem_q[rp_q];
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= wdat_i;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop_ok)  rp_q <= rp_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module instr_encoder_loader #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] wr_count,
  output logic        err
);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic [31:0] enc_word;
  logic        enc_bad;
  logic        addi_ok, b_ok, j_ok;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;

  logic [31:0] addr_q, addr_d;
  logic [15:0] wc_q, wc_d;
  logic        err_q, err_d;

  // Immediate fits when all bits above the field's sign bit equal it; branch/jump offsets must be even.
  assign addi_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign b_ok    = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
  assign j_ok    = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];

  // R-type funct3/funct7 selection from the ALU op.
  always_comb begin
    f3 = 3'b000;
    f7 = 7'b0000000;
    case (in_op)
      4'd1:    f7 = 7'b0100000;
      4'd2:    f3 = 3'b001;
      4'd3:    f3 = 3'b010;
      4'd4:    f3 = 3'b100;
      4'd5:    f3 = 3'b101;
      4'd6: begin
        f3 = 3'b101;
        f7 = 7'b0100000;
      end
      4'd7:    f3 = 3'b110;
      4'd8:    f3 = 3'b111;
      default: ;
    endcase
  end

  // Field-to-word encoder; out-of-range immediates are truncated but flagged.
  always_comb begin
    enc_word = NOP;
    enc_bad  = 1'b0;
    case (in_op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        enc_word = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
      end
      4'd9: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
        enc_bad  = !addi_ok;
      end
      4'd10, 4'd11: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b00, in_op[0],
                    in_imm[4:1], in_imm[11], 7'b1100011};
        enc_bad  = !b_ok;
      end
      4'd12: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        enc_bad  = !j_ok;
      end
      4'd13: begin
        enc_word = {in_imm[31:12], in_rd, 7'b0110111};
      end
      default: begin
        enc_word = NOP;
        enc_bad  = 1'b1;
      end
    endcase
  end

  // start wins over both stream handshakes in the same cycle.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready && !start;
  assign mem_we   = !fifo_empty;
  assign pop      = mem_we && mem_ready && !start;

  fifo_sync #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (start),
    .push_i  (push),
    .wdat_i  (enc_word),
    .pop_i   (pop),
    .rdat_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Present zero rather than stale storage while nothing is queued.
  assign mem_wdata = fifo_empty ? 32'h0 : fifo_head;
  assign mem_addr  = addr_q;
  assign wr_count  = wc_q;
  assign err       = err_q;

  // Next-state for write address, write counter and sticky error.
  always_comb begin
    addr_d = addr_q;
    wc_d   = wc_q;
    err_d  = err_q;
    if (start) begin
      addr_d = BASE_ADDR;
      wc_d   = 16'h0;
      err_d  = 1'b0;
    end else begin
      if (pop) begin
        addr_d = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
        wc_d   = (wc_q == 16'hFFFF) ? wc_q : wc_q + 16'd1;
      end
      if (push && enc_bad) err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= BASE_ADDR;
      wc_q   <= 16'h0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wc_q   <= wc_d;
      err_q  <= err_d;
    end
  end
endmodule
